pipe_stage_chain: RTL and testbench
===================================

// Module: pipe_stage_chain
// PURPOSE
//  Parametrised N-stage pipeline register chain with stall, flush, drain-on-halt and
//  RAW forwarding lookup. Successor to the fixed three-stage hand-wired CPU pipeline.
//  Carries {data, dest, reg_wr} per stage with a valid bit. Sits between decode and
//  writeback; the decoder queries it for forwarded operands.
// PARAMETERS
//  STAGES     3   pipeline depth, >=2; stage 0 youngest, STAGES-1 is the output stage
//  DATA_W     32  payload width per stage
//  REG_W      3   destination register index width
//  ZERO_REG   1   1: dest index 0 is never forwarded (R0 handled elsewhere)
// PORTS
//  clk         in   1        clock, all state on rising edge
//  rst         in   1        asynchronous, active-high reset
//  in_valid    in   1        new entry offered to stage 0
//  in_data     in   DATA_W   payload
//  in_dest     in   REG_W    destination register index
//  in_reg_wr   in   1        entry writes the register file
//  in_ready    out  1        entry accepted this cycle when in_valid && in_ready
//  stall       in   1        freeze all stages
//  flush       in   1        kill all in-flight entries
//  halt_sys    in   1        request halt: stop intake, drain, then halt
//  src1,src2   in   REG_W    forwarding lookup indices
//  fwd1_hit    out  1        src1 matches an in-flight writer
//  fwd1_data   out  DATA_W   payload of the youngest matching stage (0 if no hit)
//  fwd2_hit    out  1        same as fwd1_hit, for src2
//  fwd2_data   out  DATA_W   same as fwd1_data, for src2
//  out_valid   out  1        stage STAGES-1 holds a live entry
//  out_data    out  DATA_W   payload of stage STAGES-1
//  out_dest    out  REG_W    destination of stage STAGES-1
//  out_reg_wr  out  1        reg_wr of stage STAGES-1 (gated by out_valid)
//  halted      out  1        FSM in HALTED
// BEHAVIOUR
//  Reset: all valid bits, payloads, dests and reg_wr bits = 0; state = RUN.
//    in_ready = 1 once reset deasserts; halted = 0.
//  Reset during any state aborts the operation immediately.
//  Advance (no stall, no flush): stage[i] <= stage[i-1] for i >= 1.
//    stage0 <= input when (in_valid && in_ready), else a bubble (valid = 0).
//  Latency: an entry accepted at edge k is presented on out_* after edge k+STAGES-1,
//    i.e. STAGES cycles after it was offered.
//  Stall: every stage holds its contents; in_ready = 0; output stays on the held entry.
//  Flush: all valid bits cleared at the next edge; input is not captured.
//    Flush overrides stall. Payload registers may hold stale data, but reg_wr and
//    out_reg_wr are gated by valid.
//  Priority: rst > flush > stall > advance.
//  in_ready = (state == RUN) && !stall && !halt_sys.
//  FSM:
//    RUN -> DRAIN when halt_sys is sampled high.
//    DRAIN: no intake; stages keep advancing (stall still freezes them); bubbles enter.
//    DRAIN -> HALTED at the edge where every valid bit, including the incoming
//      shift, would be 0. A flush during DRAIN therefore reaches HALTED next edge.
//    HALTED: sticky until rst; all stages frozen; halted = 1.
//    halt_sys deasserting mid-DRAIN does not return the FSM to RUN.
//  Forwarding (combinational):
//    hit on stage i when valid[i] && reg_wr[i] && dest[i] == src.
//    With ZERO_REG = 1, src == 0 never hits.
//    Multiple hits: the lowest index (youngest) wins.
//    Lookup uses current register contents and is unaffected by stall.
//  All widths are exact; no arithmetic except the optional counters.
// CONFIGURATION
//  PIPE_PERF_EN defined: adds outputs perf_stall_cnt[15:0] and perf_bubble_cnt[15:0].
//    perf_stall_cnt increments on each cycle with stall && state == RUN.
//    perf_bubble_cnt increments on each cycle with !out_valid && state == RUN.
//    Both saturate at 16'hFFFF. Both are cleared by rst and by flush.
//  PIPE_PERF_EN undefined: those ports and registers do not exist; no other change.
// TESTING
//  T1 STAGES=3: offer data 0x11, 0x22, 0x33 on consecutive cycles, no stall
//     -> out_valid rises 3 cycles later; out_data reads 0x11, 0x22, 0x33 in order.
//  T2 stage1 holds {dest 5, reg_wr 1, 0xAA} and stage2 holds {dest 5, reg_wr 1, 0xBB}; src1 = 5
//     -> fwd1_hit = 1, fwd1_data = 0xAA.
//     Set src1 = 0 (ZERO_REG = 1) -> fwd1_hit = 0, fwd1_data = 0.
//  T3 pipe full; assert stall for 2 cycles -> outputs frozen, in_ready = 0.
//     Assert flush together with stall -> all valid bits 0 after one edge.
//  T4 pipe full; pulse halt_sys for 1 cycle -> in_ready drops immediately.
//     Remaining entries drain in order; halted = 1 exactly one edge after the last
//     out_valid; stays 1 until rst.
//  T5 assert rst asynchronously mid-DRAIN -> out_valid and halted = 0 with no clock
//     edge; in_ready = 1 after release.
//  T6 PIPE_PERF_EN defined: 4 stall cycles then flush -> perf_stall_cnt reads 4 before
//     the flush and 0 after it.
//     Separately, force perf_stall_cnt to 16'hFFFF, then stall -> value holds at 16'hFFFF.

Source files
------------

// File: rtl/pipe_stage_chain.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_chain
//  Description : N-stage pipeline register chain. Each stage carries
//                {data, dest, reg_wr} plus a valid bit. Supports stall,
//                flush, drain-on-halt and a combinational RAW forwarding
//                lookup for two source operands.
//  Ports       : clk, rst (async, active-high)
//                in_valid/in_data/in_dest/in_reg_wr/in_ready : stage-0 intake
//                stall, flush, halt_sys                       : control
//                src1/src2 -> fwd1_hit/fwd1_data, fwd2_hit/fwd2_data
//                out_valid/out_data/out_dest/out_reg_wr       : last stage
//                halted                                       : FSM in HALTED
//  Option      : PIPE_PERF_EN adds perf_stall_cnt / perf_bubble_cnt outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_chain #(
    parameter int STAGES   = 3,
    parameter int DATA_W   = 32,
    parameter int REG_W    = 3,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [REG_W-1:0]  in_dest,
    input  logic              in_reg_wr,
    output logic              in_ready,
    input  logic              stall,
    input  logic              flush,
    input  logic              halt_sys,
    input  logic [REG_W-1:0]  src1,
    input  logic [REG_W-1:0]  src2,
    output logic              fwd1_hit,
    output logic [DATA_W-1:0] fwd1_data,
    output logic              fwd2_hit,
    output logic [DATA_W-1:0] fwd2_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [REG_W-1:0]  out_dest,
    output logic              out_reg_wr,
    output logic              halted
`ifdef PIPE_PERF_EN
    ,
    output logic [15:0]       perf_stall_cnt,
    output logic [15:0]       perf_bubble_cnt
`endif
);

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_DRAIN  = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;

    logic [1:0] state_q, state_d;

    logic [STAGES-1:0]             valid_q,  valid_d;
    logic [STAGES-1:0]             reg_wr_q, reg_wr_d;
    logic [STAGES-1:0][DATA_W-1:0] data_q,   data_d;
    logic [STAGES-1:0][REG_W-1:0]  dest_q,   dest_d;

    logic accept;

    // ------------------------------------------------------------------
    // Stage next-state: flush beats stall beats advance. HALTED freezes.
    // ------------------------------------------------------------------
    always_comb begin
        valid_d  = valid_q;
        reg_wr_d = reg_wr_q;
        data_d   = data_q;
        dest_d   = dest_q;
        accept   = in_valid && in_ready;
        if (flush) begin
            valid_d = '0;
        end else if (!stall && (state_q != S_HALTED)) begin
            for (int i = 1; i < STAGES; i++) begin
                valid_d[i]  = valid_q[i-1];
                reg_wr_d[i] = reg_wr_q[i-1];
                data_d[i]   = data_q[i-1];
                dest_d[i]   = dest_q[i-1];
            end
            // Payload is loaded even for a bubble; valid alone marks liveness.
            valid_d[0]  = accept;
            reg_wr_d[0] = in_reg_wr;
            data_d[0]   = in_data;
            dest_d[0]   = in_dest;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= '0;
            reg_wr_q <= '0;
            data_q   <= '0;
            dest_q   <= '0;
        end else begin
            valid_q  <= valid_d;
            reg_wr_q <= reg_wr_d;
            data_q   <= data_d;
            dest_q   <= dest_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register / next-state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN: begin
                if (halt_sys) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Look at the post-edge valid bits so a flush or the final
                // shift-out lands in HALTED on this same edge.
                if (valid_d == '0) begin
                    state_d = S_HALTED;
                end
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_RUN;
        endcase
    end

    always_comb begin
        in_ready = (state_q == S_RUN) && !stall && !halt_sys;
        halted   = (state_q == S_HALTED);
    end

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    always_comb begin
        out_valid  = valid_q[STAGES-1];
        out_data   = data_q[STAGES-1];
        out_dest   = dest_q[STAGES-1];
        out_reg_wr = valid_q[STAGES-1] && reg_wr_q[STAGES-1];
    end

    // ------------------------------------------------------------------
    // Forwarding lookup. Scanning from oldest to youngest lets the
    // youngest matching stage overwrite any older match.
    // ------------------------------------------------------------------
    always_comb begin
        fwd1_hit  = 1'b0;
        fwd1_data = '0;
        fwd2_hit  = 1'b0;
        fwd2_data = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (valid_q[i] && reg_wr_q[i] && (dest_q[i] == src1)) begin
                fwd1_hit  = 1'b1;
                fwd1_data = data_q[i];
            end
            if (valid_q[i] && reg_wr_q[i] && (dest_q[i] == src2)) begin
                fwd2_hit  = 1'b1;
                fwd2_data = data_q[i];
            end
        end
        if ((ZERO_REG != 0) && (src1 == '0)) begin
            fwd1_hit  = 1'b0;
            fwd1_data = '0;
        end
        if ((ZERO_REG != 0) && (src2 == '0)) begin
            fwd2_hit  = 1'b0;
            fwd2_data = '0;
        end
    end

`ifdef PIPE_PERF_EN
    // ------------------------------------------------------------------
    // Saturating performance counters, cleared by rst and flush.
    // ------------------------------------------------------------------
    logic [15:0] perf_stall_q,  perf_stall_d;
    logic [15:0] perf_bubble_q, perf_bubble_d;

    always_comb begin
        perf_stall_d  = perf_stall_q;
        perf_bubble_d = perf_bubble_q;
        if (flush) begin
            perf_stall_d  = '0;
            perf_bubble_d = '0;
        end else begin
            if (stall && (state_q == S_RUN) && (perf_stall_q != 16'hFFFF)) begin
                perf_stall_d = perf_stall_q + 16'd1;
            end
            if (!valid_q[STAGES-1] && (state_q == S_RUN) && (perf_bubble_q != 16'hFFFF)) begin
                perf_bubble_d = perf_bubble_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_q  <= '0;
            perf_bubble_q <= '0;
        end else begin
            perf_stall_q  <= perf_stall_d;
            perf_bubble_q <= perf_bubble_d;
        end
    end

    always_comb begin
        perf_stall_cnt  = perf_stall_q;
        perf_bubble_cnt = perf_bubble_q;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_chain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_chain
//  Description : Self-checking bench for pipe_stage_chain (STAGES=3). Accepted
//                entries are pushed to a scoreboard queue and popped when they
//                appear on the output stage; scenario tasks add inline checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_chain;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  dest;
        logic        wr;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic [2:0]  in_dest = '0;
    logic        in_reg_wr = 1'b0;
    logic        in_ready;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        halt_sys = 1'b0;
    logic [2:0]  src1 = '0;
    logic [2:0]  src2 = '0;
    logic        fwd1_hit, fwd2_hit;
    logic [31:0] fwd1_data, fwd2_data;
    logic        out_valid;
    logic [31:0] out_data;
    logic [2:0]  out_dest;
    logic        out_reg_wr;
    logic        halted;
`ifdef PIPE_PERF_EN
    logic [15:0] perf_stall_cnt, perf_bubble_cnt;
`endif

    int   errors = 0;
    int   checks = 0;
    ent_t sb[$];
    logic tb_run  = 1'b1;
    logic mon_adv = 1'b0;

    always #5 clk = ~clk;

    pipe_stage_chain #(.STAGES(3), .DATA_W(32), .REG_W(3), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_dest(in_dest),
        .in_reg_wr(in_reg_wr), .in_ready(in_ready),
        .stall(stall), .flush(flush), .halt_sys(halt_sys),
        .src1(src1), .src2(src2),
        .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
        .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
        .out_valid(out_valid), .out_data(out_data), .out_dest(out_dest),
        .out_reg_wr(out_reg_wr), .halted(halted)
`ifdef PIPE_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_bubble_cnt(perf_bubble_cnt)
`endif
    );

    // Reference model of intake: push what the pipe should accept.
    task automatic sb_push_proc();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                sb.delete();
                tb_run  = 1'b1;
                mon_adv = 1'b0;
            end else begin
                mon_adv = !stall && !flush;
                if (flush) begin
                    sb.delete();
                end else if (in_valid && tb_run && !stall && !halt_sys) begin
                    sb.push_back('{data: in_data, dest: in_dest, wr: in_reg_wr});
                end
                if (halt_sys) tb_run = 1'b0;
            end
        end
    endtask

    // Pop and compare each fresh output entry.
    task automatic sb_pop_proc();
        ent_t e;
        forever begin
            @(negedge clk);
            if (!rst && mon_adv && out_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got data=%h dest=%0d with nothing expected", out_data, out_dest);
                end else begin
                    e = sb.pop_front();
                    if ({out_data, out_dest, out_reg_wr} !== {e.data, e.dest, e.wr}) begin
                        errors++;
                        $display("FAIL sb_entry: got %h/%0d/%b expected %h/%0d/%b",
                                 out_data, out_dest, out_reg_wr, e.data, e.dest, e.wr);
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] d, input logic [2:0] dst, input logic wr);
        in_valid  = 1'b1;
        in_data   = d;
        in_dest   = dst;
        in_reg_wr = wr;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({out_valid, halted, out_reg_wr, fwd1_hit} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000", {out_valid, halted, out_reg_wr, fwd1_hit});
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b1 || out_data !== 32'h0 || out_dest !== 3'd0) begin
            errors++;
            $display("FAIL reset_release: got rdy=%b data=%h dest=%0d expected 1/0/0", in_ready, out_data, out_dest);
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 3; i++) begin
            offer(32'h11 * (i + 1), 3'(i + 1), 1'b1);
            step();
            if (i == 1) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL latency_early: got out_valid=%b expected 0", out_valid);
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h11) begin
            errors++;
            $display("FAIL latency_first: got %b/%h expected 1/00000011", out_valid, out_data);
        end
        step();
        step();
        checks++;
        if (out_data !== 32'h33) begin
            errors++;
            $display("FAIL stream_order: got %h expected 00000033", out_data);
        end
        step();
        // Random traffic with random stalls; ordering checked by the scoreboard.
        for (int i = 0; i < 40; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            in_dest   = 3'($urandom_range(0, 7));
            in_reg_wr = 1'($urandom_range(0, 1));
            stall     = ($urandom_range(0, 3) == 0);
            step();
        end
        in_valid = 1'b0;
        stall    = 1'b0;
        repeat (5) step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL stream_drained: got %0d pending expected 0", sb.size());
        end
    endtask

    task automatic test_forward();
        offer(32'hBB, 3'd5, 1'b1); step();
        offer(32'hAA, 3'd5, 1'b1); step();
        offer(32'h77, 3'd0, 1'b1); step();
        in_valid = 1'b0;
        stall    = 1'b1;
        src1 = 3'd5; src2 = 3'd5;
        #1;
        checks++;
        if ({fwd1_hit, fwd1_data, fwd2_hit, fwd2_data} !== {1'b1, 32'hAA, 1'b1, 32'hAA}) begin
            errors++;
            $display("FAIL fwd_youngest: got %b/%h %b/%h expected 1/000000aa", fwd1_hit, fwd1_data, fwd2_hit, fwd2_data);
        end
        src1 = 3'd0; src2 = 3'd3;
        #1;
        checks++;
        if ({fwd1_hit, fwd1_data, fwd2_hit, fwd2_data} !== {1'b0, 32'h0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL fwd_miss_zero: got %b/%h %b/%h expected 0/0", fwd1_hit, fwd1_data, fwd2_hit, fwd2_data);
        end
        src2 = 3'd5;
        step();
        checks++;
        if (fwd2_hit !== 1'b1 || fwd2_data !== 32'hAA) begin
            errors++;
            $display("FAIL fwd_during_stall: got %b/%h expected 1/000000aa", fwd2_hit, fwd2_data);
        end
        stall = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_stall_flush();
        for (int i = 0; i < 3; i++) begin
            offer(32'hA1 + i, 3'(i + 1), 1'b1);
            step();
        end
        offer(32'hEE, 3'd6, 1'b1);
        stall = 1'b1;
        src1  = 3'd3;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_ready: got %b expected 0", in_ready);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'hA1 || fwd1_data !== 32'hA3) begin
                errors++;
                $display("FAIL stall_hold: got %b/%h fwd=%h expected 1/000000a1 fwd=000000a3", out_valid, out_data, fwd1_data);
            end
        end
        flush = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || fwd1_hit !== 1'b0 || out_reg_wr !== 1'b0) begin
            errors++;
            $display("FAIL flush_clear: got %b/%b/%b expected 0/0/0", out_valid, fwd1_hit, out_reg_wr);
        end
        // Flush without stall while an entry is offered: it must not be taken.
        stall = 1'b0;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        repeat (3) begin
            step();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_no_capture: got out_valid=%b expected 0", out_valid);
            end
        end
    endtask

    task automatic test_halt_drain();
        for (int i = 0; i < 3; i++) begin
            offer(32'hC1 + i, 3'(i + 1), 1'b0);
            step();
        end
        offer(32'hEE, 3'd4, 1'b1);
        halt_sys = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL halt_ready: got %b expected 0", in_ready);
        end
        step();
        halt_sys = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== (i < 2) || halted !== (i == 2) || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL drain_seq%0d: got v=%b h=%b r=%b expected v=%b h=%b r=0",
                         i, out_valid, halted, in_ready, (i < 2), (i == 2));
            end
            if (i < 2) step();
        end
        repeat (4) begin
            step();
            checks++;
            if (halted !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL halt_sticky: got h=%b r=%b v=%b expected 1/0/0", halted, in_ready, out_valid);
            end
        end
        in_valid = 1'b0;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_all: got %0d pending expected 0", sb.size());
        end
    endtask

    task automatic test_async_reset();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (halted !== 1'b0) begin
            errors++;
            $display("FAIL async_rst_halted: got %b expected 0", halted);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            offer(32'hD1 + i, 3'd7, 1'b1);
            step();
        end
        in_valid = 1'b0;
        halt_sys = 1'b1;
        step();
        halt_sys = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL async_rst_drain: got v=%b h=%b expected 0/0", out_valid, halted);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b1 || halted !== 1'b0) begin
            errors++;
            $display("FAIL async_rst_release: got r=%b h=%b expected 1/0", in_ready, halted);
        end
        offer(32'h5A5A, 3'd2, 1'b1);
        step();
        in_valid = 1'b0;
        repeat (4) step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL post_reset_flow: got %0d pending expected 0", sb.size());
        end
    endtask

`ifdef PIPE_PERF_EN
    task automatic test_perf();
        pulse_reset();
        flush = 1'b1;
        step();
        flush = 1'b0;
        stall = 1'b1;
        repeat (4) step();
        checks++;
        if (perf_stall_cnt !== 16'd4 || perf_bubble_cnt !== 16'd4) begin
            errors++;
            $display("FAIL perf_count: got %0d/%0d expected 4/4", perf_stall_cnt, perf_bubble_cnt);
        end
        stall = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (perf_stall_cnt !== 16'd0 || perf_bubble_cnt !== 16'd0) begin
            errors++;
            $display("FAIL perf_flush: got %0d/%0d expected 0/0", perf_stall_cnt, perf_bubble_cnt);
        end
        stall = 1'b1;
        repeat (65540) @(posedge clk);
        #1;
        checks++;
        if (perf_stall_cnt !== 16'hFFFF || perf_bubble_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL perf_saturate: got %h/%h expected ffff/ffff", perf_stall_cnt, perf_bubble_cnt);
        end
        step();
        checks++;
        if (perf_stall_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL perf_sat_hold: got %h expected ffff", perf_stall_cnt);
        end
        stall = 1'b0;
    endtask
`endif

    initial begin
        fork
            sb_push_proc();
            sb_pop_proc();
        join_none
        test_reset();
        test_stream();
        test_forward();
        test_stall_flush();
        test_halt_drain();
        test_async_reset();
`ifdef PIPE_PERF_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
